// File: rtl/biu_constants_pkg.sv
// Bus interface unit access attribute types shared by the cache pipeline.
package biu_constants_pkg;

    typedef logic [2:0] biu_size_t;
    typedef logic [2:0] biu_prot_t;

    localparam biu_size_t BYTE  = 3'b000;
    localparam biu_size_t HWORD = 3'b001;
    localparam biu_size_t WORD  = 3'b010;
    localparam biu_size_t DWORD = 3'b011;

    localparam biu_prot_t PROT_DATA       = 3'b000;
    localparam biu_prot_t PROT_PRIVILEGED = 3'b001;
    localparam biu_prot_t PROT_NONSECURE  = 3'b010;

endpackage

// File: rtl/riscv_cache_pkg.sv
// Cache geometry helpers and the write buffer entry layout.
package riscv_cache_pkg;

    localparam int WB_XLEN = 32;

    typedef struct packed {
        logic [WB_XLEN-1:0]   adr;
        logic [WB_XLEN-1:0]   data;
        logic [WB_XLEN/8-1:0] be;
    } wbuf_entry_t;

    // SIZE is expressed in kilobytes
    function automatic int no_of_sets(input int size, input int block_size, input int ways);
        return (size * 1024 * 8) / block_size / ways;
    endfunction

    function automatic int no_of_block_offset_bits(input int block_size);
        return $clog2(block_size / 8);
    endfunction

    function automatic int no_of_index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int no_of_tag_bits(input int xlen, input int idx_bits, input int offs_bits);
        return xlen - idx_bits - offs_bits;
    endfunction

endpackage

// File: rtl/riscv_cache_wbuf.sv
// Store FIFO between the cache setup stage and the memory stage.
// Optional youngest-match store forwarding under RISCV_CACHE_WB_FWD_EN.
module riscv_cache_wbuf
    import riscv_cache_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int WB_DEPTH = 4
)(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [XLEN-1:0]     adr_i,
    input  logic [XLEN-1:0]     d_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic                ack_i,
`ifdef RISCV_CACHE_WB_FWD_EN
    input  logic                lookup_en_i,
    input  logic                flush_i,
    input  logic [XLEN-1:2]     lookup_adr_i,
    output logic                fwd_hit_o,
    output logic [XLEN-1:0]     fwd_data_o,
    output logic [XLEN/8-1:0]   fwd_be_o,
`endif
    output logic                valid_o,
    output logic                full_o,
    output logic                pop_o,
    output logic [XLEN-1:0]     head_adr_o,
    output logic [XLEN-1:0]     head_data_o,
    output logic [XLEN/8-1:0]   head_be_o
);

    localparam int PTR_BITS = $clog2(WB_DEPTH);

    logic [XLEN-1:0]     mem_adr  [WB_DEPTH];
    logic [XLEN-1:0]     mem_data [WB_DEPTH];
    logic [XLEN/8-1:0]   mem_be   [WB_DEPTH];
    logic [PTR_BITS-1:0] rd_ptr, wr_ptr;
    logic [PTR_BITS:0]   count;

    assign valid_o     = (count != '0);
    assign full_o      = (count == (PTR_BITS+1)'(WB_DEPTH));
    assign pop_o       = valid_o & ack_i;
    assign head_adr_o  = mem_adr[rd_ptr];
    assign head_data_o = mem_data[rd_ptr];
    assign head_be_o   = mem_be[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_o)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_i, pop_o})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; an entry is only observable while count covers it
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_adr[wr_ptr]  <= adr_i;
            mem_data[wr_ptr] <= d_i;
            mem_be[wr_ptr]   <= be_i;
        end
    end

`ifdef RISCV_CACHE_WB_FWD_EN
    logic                hit_c;
    logic [XLEN-1:0]     data_c;
    logic [XLEN/8-1:0]   be_c;
    logic [PTR_BITS-1:0] slot;

    // Walk oldest to youngest so the last match wins; the entry leaving this cycle is skipped
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        be_c   = '0;
        slot   = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            slot = rd_ptr + PTR_BITS'(i);
            if (((PTR_BITS+1)'(i) < count) && !((i == 0) && pop_o) &&
                (mem_adr[slot][XLEN-1:2] == lookup_adr_i)) begin
                hit_c  = 1'b1;
                data_c = mem_data[slot];
                be_c   = mem_be[slot];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_hit_o  <= 1'b0;
            fwd_data_o <= '0;
            fwd_be_o   <= '0;
        end else if (flush_i) begin
            fwd_hit_o  <= 1'b0;
        end else if (lookup_en_i) begin
            fwd_hit_o  <= hit_c;
            fwd_data_o <= data_c;
            fwd_be_o   <= be_c;
        end
    end
`endif

endmodule

// File: rtl/riscv_cache_setup_wbuf.sv
// Cache address setup stage with a FIFO store buffer drained by the memory stage.
// Store forwarding is built only when RISCV_CACHE_WB_FWD_EN is defined.
module riscv_cache_setup_wbuf
    import riscv_cache_pkg::*;
    import biu_constants_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SIZE       = 64,
    parameter int BLOCK_SIZE = XLEN,
    parameter int WAYS       = 2,
    parameter int WB_DEPTH   = 4,

    localparam int SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
    localparam int BLK_OFFS_BITS = no_of_block_offset_bits(BLOCK_SIZE),
    localparam int IDX_BITS      = no_of_index_bits(SETS),
    localparam int TAG_BITS      = no_of_tag_bits(XLEN, IDX_BITS, BLK_OFFS_BITS)
)(
    input  logic                rst_ni,
    input  logic                clk_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic                lock_i,
    input  logic                is_cacheable_i,
    input  logic                is_misaligned_i,
    input  logic [XLEN-1:0]     adr_i,
    input  biu_size_t           size_i,
    input  biu_prot_t           prot_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic [XLEN-1:0]     d_i,
    output logic                req_o,
    output logic                lock_o,
    output logic                is_cacheable_o,
    output logic                is_misaligned_o,
    output logic [XLEN-1:0]     adr_o,
    output biu_size_t           size_o,
    output biu_prot_t           prot_o,
    output logic [IDX_BITS-1:0] tag_idx_o,
    output logic [IDX_BITS-1:0] dat_idx_o,
    output logic [TAG_BITS-1:0] core_tag_o,
    output logic                busy_o,
    output logic                wb_valid_o,
    output logic [XLEN-1:0]     wb_adr_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic [XLEN/8-1:0]   wb_be_o,
    input  logic                wb_ack_i,
    output logic                wb_fwd_hit_o,
    output logic [XLEN-1:0]     wb_fwd_data_o,
    output logic [XLEN/8-1:0]   wb_fwd_be_o
);

    logic [IDX_BITS-1:0] adr_idx, idx_dly;
    logic                flush_dly;
    logic                wb_full, wb_pop, wb_push;

    assign adr_idx = adr_i[BLK_OFFS_BITS +: IDX_BITS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_o           <= 1'b0;
            lock_o          <= 1'b0;
            is_cacheable_o  <= 1'b0;
            is_misaligned_o <= 1'b0;
            adr_o           <= '0;
            size_o          <= '0;
            prot_o          <= '0;
            core_tag_o      <= '0;
            flush_dly       <= 1'b0;
            idx_dly         <= '0;
        end else begin
            flush_dly <= flush_i;
            if (flush_i)       req_o <= 1'b0;
            else if (!stall_i) req_o <= req_i;
            if (!stall_i) begin
                lock_o          <= lock_i;
                is_cacheable_o  <= is_cacheable_i;
                is_misaligned_o <= is_misaligned_i;
                adr_o           <= adr_i;
                size_o          <= size_i;
                prot_o          <= prot_i;
                core_tag_o      <= adr_i[XLEN-1 -: TAG_BITS];
            end
            if (!stall_i || flush_dly) idx_dly <= adr_idx;
        end
    end

    // After a flush the memories must re-read at the new address even if still stalled
    assign tag_idx_o = (stall_i && !flush_dly) ? idx_dly : adr_idx;
    assign dat_idx_o = tag_idx_o;

    // A pop in the same cycle frees the slot, so a full buffer still accepts the store
    assign wb_push = req_i & we_i & ~stall_i & ~flush_i & (~wb_full | wb_pop);
    assign busy_o  = wb_full & ~wb_pop & req_i & we_i;

    riscv_cache_wbuf #(
        .XLEN     (XLEN),
        .WB_DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (wb_push),
        .adr_i        (adr_i),
        .d_i          (d_i),
        .be_i         (be_i),
        .ack_i        (wb_ack_i),
`ifdef RISCV_CACHE_WB_FWD_EN
        .lookup_en_i  (~stall_i),
        .flush_i      (flush_i),
        .lookup_adr_i (adr_i[XLEN-1:2]),
        .fwd_hit_o    (wb_fwd_hit_o),
        .fwd_data_o   (wb_fwd_data_o),
        .fwd_be_o     (wb_fwd_be_o),
`endif
        .valid_o      (wb_valid_o),
        .full_o       (wb_full),
        .pop_o        (wb_pop),
        .head_adr_o   (wb_adr_o),
        .head_data_o  (wb_data_o),
        .head_be_o    (wb_be_o)
    );

`ifndef RISCV_CACHE_WB_FWD_EN
    assign wb_fwd_hit_o  = 1'b0;
    assign wb_fwd_data_o = '0;
    assign wb_fwd_be_o   = '0;
`endif

endmodule

// File: tb/tb_riscv_cache_setup_wbuf.sv
// Bench for riscv_cache_setup_wbuf: queue-based reference model plus directed literal checks.
module tb_riscv_cache_setup_wbuf;
    import biu_constants_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    // 64 KB, 32-bit blocks, 2 ways -> 8192 sets: offset 2 bits, index 13 bits, tag 17 bits
    localparam int OFFS  = 2;
    localparam int IDXW  = 13;
    localparam int TAGW  = 17;

    logic clk = 1'b0, rst_n = 1'b0;
    logic stall = 0, flush = 0, req = 0, we = 0, lock = 0, cach = 0, mis = 0, ack = 0;
    logic [31:0] adr = '0, d = '0;
    logic [3:0]  be = '0;
    biu_size_t   size = '0;
    biu_prot_t   prot = '0;

    logic req_o, lock_o, cach_o, mis_o, busy_o, wb_valid_o, fwd_hit_o;
    logic [31:0] adr_o, wb_adr_o, wb_data_o, fwd_data_o;
    biu_size_t size_o;
    biu_prot_t prot_o;
    logic [IDXW-1:0] tag_idx_o, dat_idx_o;
    logic [TAGW-1:0] core_tag_o;
    logic [3:0] wb_be_o, fwd_be_o;

    riscv_cache_setup_wbuf #(
        .XLEN(XLEN), .SIZE(64), .BLOCK_SIZE(32), .WAYS(2), .WB_DEPTH(DEPTH)
    ) dut (
        .rst_ni(rst_n), .clk_i(clk), .stall_i(stall), .flush_i(flush),
        .req_i(req), .we_i(we), .lock_i(lock), .is_cacheable_i(cach), .is_misaligned_i(mis),
        .adr_i(adr), .size_i(size), .prot_i(prot), .be_i(be), .d_i(d),
        .req_o(req_o), .lock_o(lock_o), .is_cacheable_o(cach_o), .is_misaligned_o(mis_o),
        .adr_o(adr_o), .size_o(size_o), .prot_o(prot_o),
        .tag_idx_o(tag_idx_o), .dat_idx_o(dat_idx_o), .core_tag_o(core_tag_o),
        .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_adr_o(wb_adr_o),
        .wb_data_o(wb_data_o), .wb_be_o(wb_be_o), .wb_ack_i(ack),
        .wb_fwd_hit_o(fwd_hit_o), .wb_fwd_data_o(fwd_data_o), .wb_fwd_be_o(fwd_be_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int checks = 0, failures = 0;

    // model of registered outputs
    logic m_req = 0, m_lock, m_cach, m_mis, m_regs_known = 0;
    logic [31:0] m_adr;
    biu_size_t m_size;
    biu_prot_t m_prot;
    logic m_flush_dly = 0, m_idx_known = 0;
    logic [IDXW-1:0] m_idx_dly;
    logic m_fwd_hit = 0;
    logic [31:0] m_fwd_data;
    logic [3:0]  m_fwd_be;

    function automatic logic [IDXW-1:0] aidx(input logic [31:0] a);
        return IDXW'(a >> OFFS);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock: check combinational outputs, advance model at the edge, check registered outputs
    task automatic step();
        logic pop, full, push, f_hit;
        logic [31:0] f_data;
        logic [3:0] f_be;
        logic [IDXW-1:0] e_idx;
        #1;
        pop = 0; push = 0; f_hit = 0; f_data = '0; f_be = '0;
        if (!rst_n) begin
            chk("rst_wb_valid", wb_valid_o, 0);
            chk("rst_busy", busy_o, 0);
        end else begin
            pop  = (q.size() != 0) && ack;
            full = (q.size() == DEPTH);
            push = req && we && !stall && !flush && (!full || pop);
            chk("wb_valid", wb_valid_o, q.size() != 0);
            chk("busy", busy_o, full && !pop && req && we);
            if (q.size() != 0) begin
                chk("head_adr", wb_adr_o, q[0].adr);
                chk("head_data", wb_data_o, q[0].data);
                chk("head_be", wb_be_o, q[0].be);
            end
            if (stall && !m_flush_dly) begin
                if (m_idx_known) begin
                    chk("tag_idx_hold", tag_idx_o, m_idx_dly);
                    chk("dat_idx_hold", dat_idx_o, m_idx_dly);
                end
            end else begin
                e_idx = aidx(adr);
                chk("tag_idx", tag_idx_o, e_idx);
                chk("dat_idx", dat_idx_o, e_idx);
            end
            for (int i = 0; i < q.size(); i++)
                if (!(i == 0 && pop) && q[i].adr[31:2] == adr[31:2]) begin
                    f_hit = 1; f_data = q[i].data; f_be = q[i].be;
                end
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_req = 0; m_fwd_hit = 0; m_flush_dly = 0;
            m_idx_known = 0; m_regs_known = 0;
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{adr, d, be});
            if (!stall || m_flush_dly) begin m_idx_dly = aidx(adr); m_idx_known = 1; end
            m_flush_dly = flush;
            if (flush) m_req = 0; else if (!stall) m_req = req;
            if (!stall) begin
                m_adr = adr; m_size = size; m_prot = prot;
                m_lock = lock; m_cach = cach; m_mis = mis; m_regs_known = 1;
            end
            if (flush) m_fwd_hit = 0;
            else if (!stall) begin m_fwd_hit = f_hit; m_fwd_data = f_data; m_fwd_be = f_be; end
        end
        #1;
        chk("req_o", req_o, m_req);
        if (m_regs_known) begin
            chk("adr_o", adr_o, m_adr);
            chk("size_o", size_o, m_size);
            chk("prot_o", prot_o, m_prot);
            chk("attr_o", {lock_o, cach_o, mis_o}, {m_lock, m_cach, m_mis});
            chk("core_tag", core_tag_o, m_adr[31 -: TAGW]);
        end
`ifdef RISCV_CACHE_WB_FWD_EN
        chk("fwd_hit", fwd_hit_o, m_fwd_hit);
        if (m_fwd_hit) begin
            chk("fwd_data", fwd_data_o, m_fwd_data);
            chk("fwd_be", fwd_be_o, m_fwd_be);
        end
`else
        chk("fwd_tied", {fwd_hit_o, fwd_data_o, fwd_be_o}, '0);
`endif
    endtask

    task automatic idle();
        req = 0; we = 0; stall = 0; flush = 0; ack = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] dd, input logic [3:0] b);
        req = 1; we = 1; stall = 0; flush = 0; ack = 0; adr = a; d = dd; be = b;
        step();
        idle();
    endtask

    task automatic drain_expect(input logic [31:0] a);
        idle(); ack = 1;
        #1 chk("drain_head", wb_adr_o, a);
        step();
        ack = 0;
    endtask

    initial begin
        // reset and idle
        idle();
        rst_n = 0;
        repeat (3) step();
        chk("reset_req_o", req_o, 0);
        chk("reset_wb_valid", wb_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        rst_n = 1;

        // index tracking, stall hold, flush during stall
        adr = 32'h100;
        #1 chk("idx_0x100", tag_idx_o, 13'h40);
        step();
        adr = 32'h2C0; stall = 1;
        #1 chk("idx_stall_hold", tag_idx_o, 13'h40);
        step();
        flush = 1;
        #1 chk("idx_flush_cycle", tag_idx_o, 13'h40);
        step();
        flush = 0;
        #1 chk("idx_after_flush", tag_idx_o, 13'hB0);
        step();
        idle();
        step();

        // fill and backpressure
        for (int k = 0; k < 4; k++) store(32'h200 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 4'hF);
        req = 1; we = 1; adr = 32'h210; d = 32'hC0DE_0004; be = 4'hF;
        #1 chk("busy_full", busy_o, 1);
        step();
        ack = 1;
        #1 chk("busy_released_by_ack", busy_o, 0);
        step();
        idle();
        drain_expect(32'h204); drain_expect(32'h208);
        drain_expect(32'h20C); drain_expect(32'h210);
        #1 chk("drained_empty", wb_valid_o, 0);
        step();

        // FIFO order across pointer wrap
        store(32'h10, 32'h1010, 4'h1); store(32'h14, 32'h1414, 4'h3);
        store(32'h18, 32'h1818, 4'h7); store(32'h1C, 32'h1C1C, 4'hF);
        ack = 1; step(); step(); ack = 0;
        store(32'h20, 32'h2020, 4'h8); store(32'h24, 32'h2424, 4'hC);
        drain_expect(32'h18); drain_expect(32'h1C);
        drain_expect(32'h20); drain_expect(32'h24);

        // flush blocks a push but keeps buffered stores
        store(32'h30, 32'h3030, 4'hF); store(32'h34, 32'h3434, 4'hF);
        req = 1; we = 1; flush = 1; adr = 32'h38; d = 32'h3838; be = 4'hF;
        step();
        idle();
        chk("flush_req_o", req_o, 0);
        drain_expect(32'h30); drain_expect(32'h34);
        #1 chk("flush_no_push", wb_valid_o, 0);
        step();

`ifdef RISCV_CACHE_WB_FWD_EN
        store(32'h40, 32'hAAAA_0000, 4'hF);
        store(32'h40, 32'h1234_5678, 4'b0011);
        req = 1; we = 0; adr = 32'h40;
        step();
        chk("fwd_hit_lit", fwd_hit_o, 1);
        chk("fwd_data_lit", fwd_data_o, 32'h1234_5678);
        chk("fwd_be_lit", fwd_be_o, 4'b0011);
        adr = 32'h44;
        step();
        chk("fwd_miss_lit", fwd_hit_o, 0);
        idle(); ack = 1; step(); step(); ack = 0;
`endif

        // reset while entries are buffered
        store(32'h50, 32'h5050, 4'hF); store(32'h54, 32'h5454, 4'hF);
        ack = 1;
        #2 rst_n = 0;
        #1 chk("midreset_valid", wb_valid_o, 0);
        step();
        rst_n = 1; ack = 0;
        step();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            req   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            ack   = ($urandom_range(0, 9) < 4);
            lock  = $urandom_range(0, 1);
            cach  = $urandom_range(0, 1);
            mis   = $urandom_range(0, 1);
            size  = biu_size_t'($urandom_range(0, 7));
            prot  = biu_prot_t'($urandom_range(0, 7));
            adr   = ($urandom_range(0, 3) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 7) * 4);
            d     = $urandom;
            be    = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
